// File: rtl/clint_slave.sv
// CLINT register responder: owns mtime/mtimecmp, advances mtime on a prescaled tick,
// answers single-beat reads and byte-masked writes, and drives a registered timer-pending level.
module clint_slave #(
    parameter logic [63:0] BASE     = 64'h0200_0000,
    parameter int          PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wen,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mtip,
    output logic [63:0] mtime_o
);

    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
    localparam logic [63:0] ADDR_CMP   = BASE + 64'h4000;
    localparam logic [63:0] ADDR_TIME  = BASE + 64'hBFF8;

    state_t      state_reg, state_next;
    logic [15:0] presc_reg;
    logic [63:0] mtime_reg, mtimecmp_reg, rdata_reg;
    logic        err_reg, mtip_reg;

    logic        tick, accept, hit_cmp, hit_time, wr_cmp, wr_time;
    logic [63:0] cmp_merged, time_merged, rdata_next;

    assign tick     = (presc_reg == PRESC_LAST);
    assign accept   = req_valid && (state_reg == IDLE);
    assign hit_cmp  = (req_addr == ADDR_CMP);
    assign hit_time = (req_addr == ADDR_TIME);
    assign wr_cmp   = accept && req_wen && hit_cmp;
    assign wr_time  = accept && req_wen && hit_time;

    // Byte-lane merge of write data into the current register contents
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_merge
            assign cmp_merged[8*gi +: 8]  = req_wmask[gi] ? req_wdata[8*gi +: 8] : mtimecmp_reg[8*gi +: 8];
            assign time_merged[8*gi +: 8] = req_wmask[gi] ? req_wdata[8*gi +: 8] : mtime_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        rdata_next = 64'd0;
        if (!req_wen && hit_cmp)
            rdata_next = mtimecmp_reg;
        else if (!req_wen && hit_time)
            rdata_next = mtime_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg    <= 16'd0;
            mtime_reg    <= 64'd0;
            mtimecmp_reg <= '1;
            mtip_reg     <= 1'b0;
            rdata_reg    <= 64'd0;
            err_reg      <= 1'b0;
        end else begin
            presc_reg <= tick ? 16'd0 : presc_reg + 16'd1;
            // A software write to mtime overrides the increment of a coincident tick
            if (wr_time)
                mtime_reg <= time_merged;
            else if (tick)
                mtime_reg <= mtime_reg + 64'd1;
            if (wr_cmp)
                mtimecmp_reg <= cmp_merged;
            mtip_reg <= (mtime_reg >= mtimecmp_reg);
            if (accept) begin
                rdata_reg <= rdata_next;
                err_reg   <= !(hit_cmp || hit_time);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign resp_rdata = rdata_reg;
    assign resp_err   = err_reg;
    assign mtip       = mtip_reg;
    assign mtime_o    = mtime_reg;

endmodule

// File: tb/tb_clint_slave.sv
// Randomized scoreboard bench for clint_slave; mtime is modelled arithmetically from the
// count of clock edges since reset or since the last mtime write.
module tb_clint_slave;

    localparam logic [63:0] BASE = 64'h0200_0000;
    localparam int          PS   = 4;
    localparam int          NCYC = 6000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = 64'd0;
    logic        req_wen = 1'b0;
    logic [63:0] req_wdata = 64'd0;
    logic [7:0]  req_wmask = 8'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mtip;
    logic [63:0] mtime_o;

    always #5 clk = ~clk;

    clint_slave #(.BASE(BASE), .PRESCALE(PS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mtip(mtip), .mtime_o(mtime_o)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        logic [63:0] addr;
        logic        wen;
    } resp_t;

    resp_t q[$];
    int tests = 0;
    int fails = 0;
    int stall = 0;
    int txn   = 0;

    // Reference model: mtime = last written value + ticks elapsed since that write.
    // A tick falls on every edge whose 0-based index k satisfies k % PS == PS-1.
    logic [63:0]     m_w     = 64'd0;
    longint unsigned m_wpos  = 0;
    longint unsigned m_edges = 0;
    logic [63:0]     m_cmp   = '1;
    bit              pend_time = 0, pend_cmp = 0;
    logic [63:0]     pend_val = 64'd0;
    bit              started = 0;
    logic [63:0]     exp_mtime = 64'd0;
    logic            exp_mtip = 1'b0;

    function automatic logic [63:0] cur_mtime();
        return m_w + 64'(m_edges / PS) - 64'(m_wpos / PS);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] data,
                                          input logic [7:0] mask);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++)
            if (mask[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus and model update, one step shortly after each rising edge
    initial begin
        logic [63:0] prev_t, prev_c, addr, wdata;
        logic [7:0]  mask;
        logic        wen, is_cmp, is_time;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            prev_t = cur_mtime();
            prev_c = m_cmp;
            if (rst) begin
                m_w = 64'd0; m_wpos = 0; m_edges = 0; m_cmp = '1;
                pend_time = 0; pend_cmp = 0;
                exp_mtip = 1'b0;
                q.delete();
            end else begin
                m_edges++;
                if (pend_time) begin m_w = pend_val; m_wpos = m_edges; end
                if (pend_cmp) m_cmp = pend_val;
                pend_time = 0; pend_cmp = 0;
                exp_mtip = (prev_t >= prev_c);
            end
            exp_mtime = cur_mtime();
            started = 1;

            rst = (cyc < 2) || ($urandom_range(0, 299) == 0);
            resp_ready = ($urandom_range(0, 3) != 0);
            if (rst) begin
                req_valid = 1'b0;
            end else begin
                req_valid = ($urandom_range(0, 2) != 0);
                case ($urandom_range(0, 5))
                    0, 1:    addr = BASE + 64'h4000;
                    2, 3:    addr = BASE + 64'hBFF8;
                    default: case ($urandom_range(0, 3))
                                 0: addr = BASE;
                                 1: addr = BASE + 64'hBFFC;
                                 2: addr = BASE + 64'h4004;
                                 default: addr = {$urandom, $urandom};
                             endcase
                endcase
                case ($urandom_range(0, 4))
                    0: wdata = cur_mtime() + 64'($urandom_range(0, 30));
                    1: wdata = cur_mtime() - 64'($urandom_range(0, 30));
                    2: wdata = '1;
                    3: wdata = {$urandom, $urandom};
                    default: wdata = 64'($urandom_range(0, 50));
                endcase
                case ($urandom_range(0, 5))
                    0: mask = 8'h00;
                    1: mask = 8'($urandom);
                    2: mask = 8'h0F;
                    default: mask = 8'hFF;
                endcase
                wen = ($urandom_range(0, 1) == 1);
                req_addr = addr; req_wdata = wdata; req_wmask = mask; req_wen = wen;
                if (req_valid && req_ready) begin
                    is_cmp  = (addr == BASE + 64'h4000);
                    is_time = (addr == BASE + 64'hBFF8);
                    if (wen && is_cmp)  begin pend_cmp = 1;  pend_val = merge(m_cmp, wdata, mask); end
                    if (wen && is_time) begin pend_time = 1; pend_val = merge(cur_mtime(), wdata, mask); end
                    q.push_back('{rdata: (!wen && is_cmp) ? m_cmp : (!wen && is_time) ? cur_mtime() : 64'd0,
                                  err: !(is_cmp || is_time), addr: addr, wen: wen});
                end
            end
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Monitor: compares DUT outputs on the falling edge against the model and scoreboard
    always @(negedge clk) begin
        if (started) begin
            check("mtime", mtime_o, exp_mtime);
            check("mtip", 64'(mtip), 64'(exp_mtip));
            if (resp_valid) begin
                stall = 0;
                check("req_ready_busy", 64'(req_ready), 64'd0);
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_resp: got resp_valid=1 expected no response pending");
                end else begin
                    check("resp_rdata", resp_rdata, q[0].rdata);
                    check("resp_err", 64'(resp_err), 64'(q[0].err));
                    if (resp_ready) begin
                        txn++;
                        $display("[TB] txn %0d %s addr=%h rdata=%h err=%0b", txn,
                                 q[0].wen ? "WR" : "RD", q[0].addr, resp_rdata, resp_err);
                        void'(q.pop_front());
                    end
                end
            end else begin
                check("req_ready_idle", 64'(req_ready), 64'd1);
                if (q.size() > 0) stall++;
                else stall = 0;
                if (stall > 2) begin
                    tests++; fails++;
                    $display("FAIL resp_timeout: got no resp_valid after %0d cycles expected within 1", stall);
                    q.delete();
                    stall = 0;
                end
            end
        end
    end

endmodule

// File: doc/clint_slave.md
Name: clint_slave

Overview:
Memory-mapped CLINT register responder on the core's 64-bit load/store request/response interface. Owns the mtime and mtimecmp registers and advances mtime on a prescaled tick. Answers single-beat reads and byte-masked writes from the LSU. Drives a registered machine-timer-pending level to the CSR/interrupt logic.

Parameters:
BASE, 64'h0200_0000, CLINT base address; mtimecmp at BASE+0x4000, mtime at BASE+0xBFF8
PRESCALE, 1, clk cycles per mtime increment; legal range 1..65535

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_addr  input  64  byte address
req_wen  input  1  1 = write, 0 = read
req_wdata  input  64  write data
req_wmask  input  8  byte enables; bit i covers wdata[8i+7:8i]
resp_valid  output  1  response present
resp_ready  input  1  requester accepts the response
resp_rdata  output  64  read data; 0 for writes and errors
resp_err  output  1  access to an unmapped or misaligned address
mtip  output  1  machine timer pending, registered
mtime_o  output  64  current mtime register value, direct

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescale counter=0, state=IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mtip=0.
- Reset during RESP discards the pending response. No partial effects survive.
- Tick: the prescale counter counts 0..PRESCALE-1. mtime increments on the edge where the counter equals PRESCALE-1, and the counter returns to 0. PRESCALE=1 means mtime increments every cycle.
- mtime wraps from 2^64-1 to 0 silently.
- FSM states IDLE and RESP:
  - IDLE: req_ready=1, resp_valid=0. On req_valid && req_ready, the request is accepted at that edge and the state goes to RESP.
  - RESP: req_ready=0, resp_valid=1. resp_rdata and resp_err stay stable until resp_valid && resp_ready, then the state returns to IDLE at that edge.
  - Latency is 1 cycle from acceptance to resp_valid. Maximum throughput is one request per 2 cycles.
- Decode at acceptance:
  - An address equal to BASE+0x4000 selects mtimecmp.
  - An address equal to BASE+0xBFF8 selects mtime.
  - Any other address sets resp_err=1 and resp_rdata=0, with no register change.
- Read: resp_rdata takes the selected register value before that edge's update.
- Write:
  - Takes effect at the acceptance edge.
  - For each byte i with req_wmask[i]=1, the register byte is replaced by the wdata byte. Other bytes are unchanged.
  - resp_rdata=0, resp_err=0.
  - A write with wmask=0 is a legal no-op.
- Write to mtime coinciding with a tick: the written value (merged) wins and that tick's increment is dropped. The prescale counter still advances and wraps normally.
- Write to mtimecmp coinciding with a tick: both take effect.
- mtip <= (mtime >= mtimecmp), an unsigned 64-bit compare of the current register values, evaluated every cycle. mtip therefore lags register changes by 1 cycle.
- mtip is a level. It deasserts only when mtimecmp is raised above mtime, or mtime is lowered below mtimecmp. No MIE/MTIE gating happens here; the CSR logic applies enables.
- req_* inputs are ignored outside IDLE. resp_ready is ignored outside RESP.

Test Plan:
1. PRESCALE=1, release rst, idle 10 cycles -> mtime_o=10, mtip=0 throughout.
2. Write mtimecmp at 0x0200_4000, wdata=0x20, wmask=0xFF, at mtime=5 -> resp_valid next cycle with err=0, rdata=0. mtip=1 exactly one cycle after mtime_o first equals 0x20.
3. Read mtime at 0x0200_BFF8 with resp_ready held low 3 cycles -> resp_valid stays 1, resp_rdata is stable at the pre-edge mtime value, req_ready=0; the state returns to IDLE on the edge where resp_ready=1.
4. From reset, write mtimecmp with wdata=0x1122_3344_5566_7788, wmask=0x0F -> mtimecmp reads back 0xFFFF_FFFF_5566_7788.
5. Read 0x0200_0000 and write 0x0200_BFFC -> resp_err=1, resp_rdata=0, mtime and mtimecmp unchanged.
6. PRESCALE=4: write mtime=0xFFFF_FFFF_FFFF_FFFF on a tick edge -> mtime holds that value, and 4 cycles later reads 0. Assert rst while in RESP -> next cycle resp_valid=0, req_ready=1, mtime_o=0.
